// File: rtl/alu_seq_pkg.sv
// Shared opcode map, sequencer states and opcode classification helpers
// for the logic-unit sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MOD  = 4'd12;

  // Store ops occupy the contiguous range OP_ADD..OP_NOT
  localparam int unsigned NUM_STORE_OPS = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIVWAIT,
    S_PUSH
  } state_e;

  function automatic logic is_store_op(input logic [3:0] op);
    return op <= OP_NOT;
  endfunction

  function automatic logic is_divmod_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_sequencer_latency_timer.sv
// Down-counter that waits out a fixed latency: loads on start, counts down
// to zero and holds there, flagging zero.
module latency_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] load_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = load_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one logic-unit operation per request: operation strobe, optional
// divider wait, then a single result push with a done pulse.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DIV_LATENCY = 20,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic       req_dst_high,
  output logic       op_add,
  output logic       op_sub,
  output logic       op_inc,
  output logic       op_dec,
  output logic       op_mul,
  output logic       op_shr,
  output logic       op_shl,
  output logic       op_band,
  output logic       op_bor,
  output logic       op_bxor,
  output logic       op_bnegate,
  output logic       push,
  output logic       push_high,
  output logic       push_div,
  output logic       push_mod,
  output logic       hold_operands,
  output logic       done,
  output logic       err
);

  if (DIV_LATENCY < 1 || DIV_LATENCY >= (1 << CNT_W)) begin : g_param_check
    $error("alu_sequencer: DIV_LATENCY must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  state_e                   state_q, state_d;
  logic [3:0]               op_q, op_d;
  logic                     dst_q, dst_d;
  logic                     tmr_start, tmr_zero;
  logic [NUM_STORE_OPS-1:0] strb_q, strb_d;
  logic                     push_q, push_d;
  logic                     push_high_q, push_high_d;
  logic                     push_div_q, push_div_d;
  logic                     push_mod_q, push_mod_d;
  logic                     hold_q, hold_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     ready_q, ready_d;

  latency_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (tmr_start),
    .load_i  (DIV_LOAD),
    .zero_o  (tmr_zero)
  );

  // Outputs are decoded from the next state so they are registered yet still
  // line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    tmr_start = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          dst_d = req_dst_high;
          if (is_store_op(req_op)) begin
            state_d = S_EXEC;
          end else if (is_divmod_op(req_op)) begin
            state_d   = S_DIVWAIT;
            tmr_start = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXEC:    state_d = S_PUSH;
      S_DIVWAIT: if (tmr_zero) state_d = S_PUSH;
      S_PUSH:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_STORE_OPS; i++) begin
      strb_d[i] = (state_d == S_EXEC) && (op_d == 4'(i));
    end
    hold_d      = (state_d == S_EXEC) || (state_d == S_DIVWAIT);
    done_d      = (state_d == S_PUSH);
    push_div_d  = (state_d == S_PUSH) && (op_d == OP_DIV);
    push_mod_d  = (state_d == S_PUSH) && (op_d == OP_MOD);
    push_high_d = (state_d == S_PUSH) && is_store_op(op_d) && dst_d;
    push_d      = (state_d == S_PUSH) && is_store_op(op_d) && !dst_d;
    ready_d     = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      dst_q       <= 1'b0;
      strb_q      <= '0;
      push_q      <= 1'b0;
      push_high_q <= 1'b0;
      push_div_q  <= 1'b0;
      push_mod_q  <= 1'b0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      strb_q      <= strb_d;
      push_q      <= push_d;
      push_high_q <= push_high_d;
      push_div_q  <= push_div_d;
      push_mod_q  <= push_mod_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end
  end

  assign op_add        = strb_q[OP_ADD];
  assign op_sub        = strb_q[OP_SUB];
  assign op_inc        = strb_q[OP_INC];
  assign op_dec        = strb_q[OP_DEC];
  assign op_mul        = strb_q[OP_MUL];
  assign op_shr        = strb_q[OP_SHR];
  assign op_shl        = strb_q[OP_SHL];
  assign op_band       = strb_q[OP_AND];
  assign op_bor        = strb_q[OP_OR];
  assign op_bxor       = strb_q[OP_XOR];
  assign op_bnegate    = strb_q[OP_NOT];
  assign push          = push_q;
  assign push_high     = push_high_q;
  assign push_div      = push_div_q;
  assign push_mod      = push_mod_q;
  assign hold_operands = hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign req_ready     = ready_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random-stream bench for alu_sequencer; a per-cycle timeline
// of expected outputs is filled in whenever a request is accepted.
module tb_alu_sequencer;

  localparam int unsigned L    = 20;
  localparam int unsigned MAXC = 8192;

  typedef struct packed {
    logic        ready, err, done, hold, push_mod, push_div, push_high, push;
    logic [10:0] strb;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_dst_high;
  logic [3:0] req_op;
  logic op_add, op_sub, op_inc, op_dec, op_mul, op_shr, op_shl;
  logic op_band, op_bor, op_bxor, op_bnegate;
  logic push, push_high, push_div, push_mod, hold_operands, done, err;

  alu_sequencer #(.DIV_LATENCY(L), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_dst_high(req_dst_high),
    .op_add(op_add), .op_sub(op_sub), .op_inc(op_inc), .op_dec(op_dec),
    .op_mul(op_mul), .op_shr(op_shr), .op_shl(op_shl), .op_band(op_band),
    .op_bor(op_bor), .op_bxor(op_bxor), .op_bnegate(op_bnegate),
    .push(push), .push_high(push_high), .push_div(push_div), .push_mod(push_mod),
    .hold_operands(hold_operands), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  ov_t         tl [MAXC];
  ov_t         idle_v;
  int unsigned edge_n    = 0;
  int unsigned acc_edge  = 0;
  int unsigned n_acc     = 0;
  int          exp_dones = 0;
  int          dut_dones = 0;
  int unsigned vectors   = 0;
  int unsigned miscomp   = 0;
  bit          started   = 1'b0;

  function automatic ov_t dut_vec();
    ov_t v;
    v.ready = req_ready; v.err = err; v.done = done; v.hold = hold_operands;
    v.push_mod = push_mod; v.push_div = push_div; v.push_high = push_high;
    v.push = push;
    v.strb = {op_bnegate, op_bxor, op_bor, op_band, op_shl, op_shr, op_mul,
              op_dec, op_inc, op_sub, op_add};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscomp++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Timeline model: a request accepted at edge t occupies cycles t+1.. and
  // the cycle after edge t is indexed t+1.
  task automatic schedule(input int unsigned t, input logic [3:0] op, input logic dst);
    int o;
    o = int'(op);
    acc_edge = t;
    n_acc++;
    if (t + L + 2 >= MAXC) return;
    if (o <= 10) begin
      tl[t+1].strb[o] = 1'b1; tl[t+1].hold = 1'b1; tl[t+1].ready = 1'b0;
      tl[t+2].done = 1'b1; tl[t+2].ready = 1'b0;
      if (dst) tl[t+2].push_high = 1'b1; else tl[t+2].push = 1'b1;
      exp_dones++;
    end else if (o == 11 || o == 12) begin
      for (int unsigned k = 1; k <= L; k++) begin
        tl[t+k].hold = 1'b1; tl[t+k].ready = 1'b0;
      end
      tl[t+L+1].done = 1'b1; tl[t+L+1].ready = 1'b0;
      if (o == 11) tl[t+L+1].push_div = 1'b1; else tl[t+L+1].push_mod = 1'b1;
      exp_dones++;
    end else begin
      tl[t+1].err = 1'b1;
    end
  endtask

  initial begin
    idle_v = '0;
    idle_v.ready = 1'b1;
    for (int unsigned i = 0; i < MAXC; i++) tl[i] = idle_v;
  end

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst_n === 1'b1 && req_valid === 1'b1 && tl[edge_n].ready)
      schedule(edge_n, req_op, req_dst_high);
  end

  always @(negedge rst_n) begin
    for (int unsigned i = edge_n + 1; i < MAXC; i++) begin
      if (tl[i].done) exp_dones--;
      tl[i] = idle_v;
    end
  end

  // Per-cycle compare plus the structural invariants
  always @(negedge clk) begin
    if (started) begin
      ov_t g;
      g = dut_vec();
      vectors++;
      if (g !== tl[edge_n+1]) begin
        miscomp++;
        $display("FAIL cycle %0d outputs: got %h, expected %h", edge_n + 1, g, tl[edge_n+1]);
      end
      vectors++;
      if ($countones({g.strb, g.push, g.push_high, g.push_div, g.push_mod}) > 1) begin
        miscomp++;
        $display("FAIL onehot cycle %0d: got %h, expected at most one strobe", edge_n + 1, g);
      end
      vectors++;
      if (op_dec && (push || push_high || push_div || push_mod)) begin
        miscomp++;
        $display("FAIL dec_vs_push cycle %0d: got dec with push, expected exclusive", edge_n + 1);
      end
      if (done === 1'b1) dut_dones++;
    end
  end

  task automatic issue(input logic [3:0] op, input logic dst, output int unsigned t);
    req_op = op; req_dst_high = dst; req_valid = 1'b1;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_edge == edge_n) begin
        t = edge_n;
        break;
      end
    end
    req_valid = 1'b0;
    if (t == 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int unsigned t, t2, n0, cnt;
    rst_n = 1'b1; req_valid = 1'b0; req_op = '0; req_dst_high = 1'b0;
    #1 rst_n = 1'b0;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_hold", hold_operands, 0);
    chk("rst_err", err, 0);
    chk("rst_add", op_add, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    // ADD to bus3
    issue(4'd0, 1'b0, t);
    @(negedge clk);
    chk("add_strobe", op_add, 1); chk("add_ready_t1", req_ready, 0); chk("add_push_t1", push, 0);
    @(negedge clk);
    chk("add_push", push, 1); chk("add_done", done, 1); chk("add_strobe_t2", op_add, 0);
    chk("add_ready_t2", req_ready, 0);
    @(negedge clk);
    chk("add_ready_t3", req_ready, 1); chk("add_done_t3", done, 0);

    // DEC to bus4
    issue(4'd3, 1'b1, t);
    @(negedge clk);
    chk("dec_strobe", op_dec, 1); chk("dec_pushh_t1", push_high, 0);
    @(negedge clk);
    chk("dec_pushh", push_high, 1); chk("dec_done", done, 1); chk("dec_strobe_t2", op_dec, 0);

    // DIV then MOD
    for (int m = 0; m < 2; m++) begin
      issue(m == 0 ? 4'd11 : 4'd12, 1'b0, t);
      @(negedge clk);
      chk("div_hold_t1", hold_operands, 1);
      repeat (L - 1) @(negedge clk);
      chk("div_hold_tL", hold_operands, 1); chk("div_done_tL", done, 0);
      @(negedge clk);
      chk(m == 0 ? "div_push" : "mod_push", m == 0 ? push_div : push_mod, 1);
      chk("div_done", done, 1); chk("div_hold_end", hold_operands, 0);
    end

    // Illegal opcode, then an immediate ADD
    issue(4'd14, 1'b0, t);
    @(negedge clk);
    chk("ill_err", err, 1); chk("ill_ready", req_ready, 1);
    chk("ill_done", done, 0); chk("ill_hold", hold_operands, 0);
    issue(4'd0, 1'b0, t2);
    chk("ill_next_accept", t2, t + 1);
    @(negedge clk);
    chk("ill_err_off", err, 0); chk("ill_then_add", op_add, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a DIV
    issue(4'd11, 1'b0, t);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    begin
      ov_t g;
      g = dut_vec();
      g.ready = 1'b0;
      chk("midrst_outputs", 32'(g), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", req_ready, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);

    // Random stream with req_valid held high
    n0 = n_acc;
    req_valid = 1'b1;
    req_op = 4'($urandom_range(0, 15)); req_dst_high = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      if (n_acc - n0 >= 200) break;
      req_op = 4'($urandom_range(0, 15)); req_dst_high = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    chk("stream_accepts", (n_acc - n0 >= 200) ? 1 : 0, 1);
    repeat (L + 5) @(negedge clk);

    chk("done_count", dut_dones, exp_dones);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end

endmodule
